// File: rtl/clk_div_prog.sv
// Runtime-programmable clock divider with duty-cycle control, shadow loading and a period-start tick.
// Optional start-phase offset port is enabled by defining CLK_DIV_PHASE_EN.
module clk_div_prog #(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned DEFAULT_DIV  = 255,
    parameter int unsigned DEFAULT_HIGH = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] div_in,
    input  logic [WIDTH-1:0] high_in,
`ifdef CLK_DIV_PHASE_EN
    input  logic [WIDTH-1:0] phase_in,
`endif
    input  logic             load,
    input  logic             restart,
    output logic             pending,
    output logic             y,
    output logic             tick,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] DIV_RST  = (DEFAULT_DIV == 0) ? ONE : WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] HIGH_RST = WIDTH'(DEFAULT_HIGH);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] div_act;
    logic [WIDTH-1:0] high_act;
    logic [WIDTH-1:0] div_sh;
    logic [WIDTH-1:0] high_sh;

    logic [WIDTH-1:0] in_div;
    logic [WIDTH-1:0] nxt_div;
    logic [WIDTH-1:0] nxt_high;
    logic [WIDTH-1:0] start_cnt;
    logic [WIDTH-1:0] seed_cnt;
    logic [WIDTH-1:0] inc_cnt;
    logic             at_end;

    // A zero divisor would give a one-cycle period with no low phase; store it as 1.
    function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] v);
        return (v == '0) ? ONE : v;
    endfunction

    // Values that take effect at the next period start: a same-edge load wins,
    // otherwise a waiting shadow, otherwise the current active pair.
    always_comb begin
        in_div   = clamp_div(div_in);
        nxt_div  = div_act;
        nxt_high = high_act;
        if (pending) begin
            nxt_div  = div_sh;
            nxt_high = high_sh;
        end
        if (load) begin
            nxt_div  = in_div;
            nxt_high = high_in;
        end
`ifdef CLK_DIV_PHASE_EN
        start_cnt = (phase_in > nxt_div) ? nxt_div : phase_in;
`else
        start_cnt = '0;
`endif
        seed_cnt = restart ? start_cnt : '0;
        inc_cnt  = count + ONE;
        at_end   = (count == div_act);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= '0;
            y        <= 1'b0;
            tick     <= 1'b0;
            pending  <= 1'b0;
            div_act  <= DIV_RST;
            high_act <= HIGH_RST;
            div_sh   <= DIV_RST;
            high_sh  <= HIGH_RST;
        end else begin
            case (state)
                IDLE: begin
                    count <= '0;
                    y     <= 1'b0;
                    tick  <= 1'b0;
                    if (en) begin
                        state    <= RUN;
                        div_act  <= nxt_div;
                        high_act <= nxt_high;
                        div_sh   <= nxt_div;
                        high_sh  <= nxt_high;
                        pending  <= 1'b0;
                        count    <= start_cnt;
                        tick     <= (start_cnt == '0);
                        y        <= (start_cnt < nxt_high);
                    end else if (load) begin
                        div_sh  <= in_div;
                        high_sh <= high_in;
                        pending <= 1'b1;
                    end else if (pending) begin
                        // No period is running, so shadows can go live on the next edge.
                        div_act  <= div_sh;
                        high_act <= high_sh;
                        pending  <= 1'b0;
                    end
                end

                RUN: begin
                    if (!en) begin
                        // Abandon the period; any pending values apply once idle.
                        state <= IDLE;
                        count <= '0;
                        y     <= 1'b0;
                        tick  <= 1'b0;
                        if (load) begin
                            div_sh  <= in_div;
                            high_sh <= high_in;
                            pending <= 1'b1;
                        end
                    end else if (restart || at_end) begin
                        div_act  <= nxt_div;
                        high_act <= nxt_high;
                        div_sh   <= nxt_div;
                        high_sh  <= nxt_high;
                        pending  <= 1'b0;
                        count    <= seed_cnt;
                        tick     <= (seed_cnt == '0);
                        y        <= (seed_cnt < nxt_high);
                    end else begin
                        count <= inc_cnt;
                        tick  <= 1'b0;
                        y     <= (inc_cnt < high_act);
                        if (load) begin
                            div_sh  <= in_div;
                            high_sh <= high_in;
                            pending <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    count <= '0;
                    y     <= 1'b0;
                    tick  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: vector table plus periodic sequences, checked through a scoreboard queue.
module tb_clk_div_prog;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] div_in;
    logic [15:0] high_in;
    logic        load;
    logic        restart;
    logic        pending;
    logic        y;
    logic        tick;
    logic [15:0] count;

    int errors;
    int checks;

    typedef struct packed {
        logic [15:0] c;
        logic        y;
        logic        t;
        logic        p;
    } exp_t;

    typedef struct {
        logic        en;
        logic        ld;
        logic        rs;
        logic [15:0] d;
        logic [15:0] h;
        exp_t        ex;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];

    clk_div_prog #(
        .WIDTH(16),
        .DEFAULT_DIV(255),
        .DEFAULT_HIGH(128)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .div_in(div_in),
        .high_in(high_in),
`ifdef CLK_DIV_PHASE_EN
        .phase_in(16'd0),
`endif
        .load(load),
        .restart(restart),
        .pending(pending),
        .y(y),
        .tick(tick),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic e, input logic l, input logic r, input logic [15:0] d,
                       input logic [15:0] h, input logic [15:0] c, input logic ey,
                       input logic et, input logic ep);
        vec_t v;
        v.en = e; v.ld = l; v.rs = r; v.d = d; v.h = h;
        v.ex = '{c: c, y: ey, t: et, p: ep};
        vecs.push_back(v);
    endtask

    task automatic compare(input string name, input int idx, input exp_t want);
        checks++;
        if ({count, y, tick, pending} !== want) begin
            errors++;
            $display("FAIL %s #%0d: got count=%0d y=%0b tick=%0b pending=%0b, want count=%0d y=%0b tick=%0b pending=%0b",
                     name, idx, count, y, tick, pending, want.c, want.y, want.t, want.p);
        end
    endtask

    // Drive one cycle of inputs, queue its expectation, and check it after the edge.
    task automatic step(input logic e, input logic l, input logic r, input logic [15:0] d,
                        input logic [15:0] h, input exp_t ex, input string name, input int idx);
        exp_t want;
        @(negedge clk);
        en = e; load = l; restart = r; div_in = d; high_in = h;
        sb.push_back(ex);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s #%0d: scoreboard empty, got 0 entries, want 1", name, idx);
        end else begin
            want = sb.pop_front();
            compare(name, idx, want);
        end
    endtask

    // Steady periodic run; optional load+restart on the first cycle installs d/h immediately.
    task automatic run_periodic(input logic with_load, input logic [15:0] d, input logic [15:0] h,
                                input int n, input string name);
        int   period;
        exp_t ex;
        period = ((d == 16'd0) ? 1 : int'(d)) + 1;
        for (int k = 0; k < n; k++) begin
            ex.c = 16'(k % period);
            ex.y = (ex.c < h);
            ex.t = (ex.c == 16'd0);
            ex.p = 1'b0;
            step(1'b1, with_load && (k == 0), with_load && (k == 0), d, h, ex, name, k);
        end
    endtask

    initial begin
        errors = 0; checks = 0;
        rst_n = 1'b0; en = 1'b0; load = 1'b0; restart = 1'b0;
        div_in = 16'd255; high_in = 16'd128;

        // Mid-period load, legacy wrap behaviour
        add(1,1,1, 9,5, 0,1,1,0);
        add(1,0,0, 0,0, 1,1,0,0);
        add(1,0,0, 0,0, 2,1,0,0);
        add(1,0,0, 0,0, 3,1,0,0);
        add(1,1,0, 4,2, 4,1,0,1);
        add(1,0,0, 0,0, 5,0,0,1);
        add(1,0,0, 0,0, 6,0,0,1);
        add(1,0,0, 0,0, 7,0,0,1);
        add(1,0,0, 0,0, 8,0,0,1);
        add(1,0,0, 0,0, 9,0,0,1);
        add(1,0,0, 0,0, 0,1,1,0);
        add(1,0,0, 0,0, 1,1,0,0);
        add(1,0,0, 0,0, 2,0,0,0);
        add(1,0,0, 0,0, 3,0,0,0);
        add(1,0,0, 0,0, 4,0,0,0);
        add(1,0,0, 0,0, 0,1,1,0);
        add(1,0,0, 0,0, 1,1,0,0);
        // Restart and enable handling
        add(1,1,1, 9,5, 0,1,1,0);
        add(1,0,0, 0,0, 1,1,0,0);
        add(1,0,0, 0,0, 2,1,0,0);
        add(1,0,0, 0,0, 3,1,0,0);
        add(1,0,0, 0,0, 4,1,0,0);
        add(1,0,0, 0,0, 5,0,0,0);
        add(1,0,1, 0,0, 0,1,1,0);
        add(1,0,0, 0,0, 1,1,0,0);
        add(1,0,0, 0,0, 2,1,0,0);
        add(1,0,0, 0,0, 3,1,0,0);
        add(1,0,0, 0,0, 4,1,0,0);
        add(1,0,0, 0,0, 5,0,0,0);
        add(0,0,0, 0,0, 0,0,0,0);
        add(0,0,0, 0,0, 0,0,0,0);
        add(1,0,0, 0,0, 0,1,1,0);
        add(1,0,0, 0,0, 1,1,0,0);
        add(0,0,1, 0,0, 0,0,0,0);
        add(0,0,1, 0,0, 0,0,0,0);
        // Load while idle, then load coinciding with wrap
        add(0,1,0, 3,1, 0,0,0,1);
        add(0,0,0, 0,0, 0,0,0,0);
        add(1,0,0, 0,0, 0,1,1,0);
        add(1,0,0, 0,0, 1,0,0,0);
        add(1,0,0, 0,0, 2,0,0,0);
        add(1,0,0, 0,0, 3,0,0,0);
        add(1,1,0, 5,3, 0,1,1,0);
        add(1,0,0, 0,0, 1,1,0,0);
        add(1,0,0, 0,0, 2,1,0,0);
        add(1,0,0, 0,0, 3,0,0,0);
        add(1,0,0, 0,0, 4,0,0,0);
        add(1,0,0, 0,0, 5,0,0,0);
        add(1,0,0, 0,0, 0,1,1,0);
        // Back-to-back loads: only the last one applies
        add(1,1,0, 7,2, 1,1,0,1);
        add(1,1,0, 2,1, 2,1,0,1);
        add(1,0,0, 0,0, 3,0,0,1);
        add(1,0,0, 0,0, 4,0,0,1);
        add(1,0,0, 0,0, 5,0,0,1);
        add(1,0,0, 0,0, 0,1,1,0);
        add(1,0,0, 0,0, 1,0,0,0);
        add(1,0,0, 0,0, 2,0,0,0);
        add(1,0,0, 0,0, 0,1,1,0);
        // Divisor 0 clamps to period 2
        add(1,1,1, 0,1, 0,1,1,0);
        add(1,0,0, 0,0, 1,0,0,0);
        add(1,0,0, 0,0, 0,1,1,0);
        add(1,0,0, 0,0, 1,0,0,0);

        repeat (3) @(posedge clk);
        #1;
        compare("reset", 0, '{c: 16'd0, y: 1'b0, t: 1'b0, p: 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 16'd255, 16'd128, '{c: 16'd0, y: 1'b0, t: 1'b0, p: 1'b0}, "idle", 0);

        run_periodic(1'b0, 16'd255, 16'd128, 512, "defaults");
        run_periodic(1'b1, 16'd7, 16'd4, 24, "legacy");

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i].en, vecs[i].ld, vecs[i].rs, vecs[i].d, vecs[i].h, vecs[i].ex, "vec", i);

        run_periodic(1'b1, 16'd9, 16'd0, 22, "high0");
        run_periodic(1'b1, 16'd9, 16'd20, 22, "high_gt_div");
        run_periodic(1'b1, 16'd200, 16'd50, 101, "pre_reset");

        // Asynchronous reset at count 100, asserted away from the clock edge
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        compare("async_reset", 0, '{c: 16'd0, y: 1'b0, t: 1'b0, p: 1'b0});
        @(posedge clk);
        #1;
        compare("async_reset_hold", 0, '{c: 16'd0, y: 1'b0, t: 1'b0, p: 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 16'd0, 16'd0, '{c: 16'd0, y: 1'b0, t: 1'b0, p: 1'b0}, "post_reset", 0);
        run_periodic(1'b0, 16'd255, 16'd128, 300, "defaults_again");

        @(negedge clk);
        en = 1'b0; load = 1'b0; restart = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
